bus_arbiter: RTL and testbench

Two-master arbiter that shares the single system bus (`Bus_if`) between the instruction-fetch port and the data-memory port of the CPU. It sits between the CPU's two `Bus_if.master` ports and the downstream address decoder. It grants exactly one master at a time, holds that grant until the transaction completes, and forwards the granted master's request downstream. Non-granted requesters are stalled.

---
 rtl/bus_arbiter_if.sv | 33 +++
 rtl/bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_bus_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus_if: one CPU-style system bus port (request, write payload, read return, interrupts).
// Latency: none; this is just a bundle of wires.
// Backpressure: the slave side drives stall; a master holds its request until stall is low.
//
// Signals
//   read, write   : request strobes from the master
//   address       : byte address of the access
//   data_wr, mask : write payload and byte-lane enables
//   stall         : slave is not done; master must hold the request
//   data_rd       : primary read return, valid in the completing cycle
//   data_rd_2     : secondary read return, same timing as data_rd
//   interrupt     : interrupt lines broadcast from the slave side
interface Bus_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] data_wr;
    logic [3:0]  mask;
    logic        stall;
    logic [31:0] data_rd;
    logic [31:0] data_rd_2;
    logic [5:0]  interrupt;

    modport master (
        output read, write, address, data_wr, mask,
        input  stall, data_rd, data_rd_2, interrupt
    );

    modport slave (
        input  read, write, address, data_wr, mask,
        output stall, data_rd, data_rd_2, interrupt
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one downstream Bus_if between the fetch port (m0) and the data port (m1).
// Latency: request in an IDLE cycle t is on ds in t+1; zero-wait access completes in t+1.
// Backpressure: owner sees ds.stall directly; any other requester is held with stall=1.
//
// Ports
//   clk  : Clock_t bundle; clk.base is the clock, clk.rst a synchronous active-high reset
//   m0   : Bus_if.slave, instruction fetch requester
//   m1   : Bus_if.slave, data requester
//   ds   : Bus_if.master, downstream toward the address decoder
//
// Parameters
//   ROUND_ROBIN : 1 = ties alternate between masters, 0 = master 1 always wins a tie

package bus_arbiter_pkg;
    typedef struct packed {
        logic base;
        logic rst;
    } Clock_t;
endpackage

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned ROUND_ROBIN = 1
) (
    input  Clock_t      clk,
    Bus_if.slave        m0,
    Bus_if.slave        m1,
    Bus_if.master       ds
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } owner_t;

    owner_t      r_owner;
    owner_t      w_owner_nxt;
    owner_t      w_owner_eff;
    logic        r_last;
    logic        w_last_nxt;

    logic        w_req0;
    logic        w_req1;
    logic        w_tie_pick1;

    logic        w_ds_read;
    logic        w_ds_write;
    logic [31:0] w_ds_address;
    logic [31:0] w_ds_data_wr;
    logic [3:0]  w_ds_mask;
    logic        w_m0_stall;
    logic        w_m1_stall;
    logic [31:0] w_m0_data_rd;
    logic [31:0] w_m0_data_rd_2;
    logic [31:0] w_m1_data_rd;
    logic [31:0] w_m1_data_rd_2;

    assign w_req0 = m0.read | m0.write;
    assign w_req1 = m1.read | m1.write;

    // On a tie: round-robin hands the bus to whoever did not have it last,
    // fixed priority always favours the data port.
    assign w_tie_pick1 = (ROUND_ROBIN != 0) ? ~r_last : 1'b1;

    // ---------------------------------------------------------------
    // State register. last resets to 1 so that m0 wins the first tie.
    // ---------------------------------------------------------------
    always_ff @(posedge clk.base) begin
        if (clk.rst) begin
            r_owner <= ST_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic. Grants are only made from IDLE, so ownership
    // can never hop directly from one master to the other.
    // ---------------------------------------------------------------
    always_comb begin
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_owner)
            ST_IDLE: begin
                if (w_req0 && w_req1) begin
                    w_owner_nxt = w_tie_pick1 ? ST_BUSY1 : ST_BUSY0;
                    w_last_nxt  = w_tie_pick1;
                end else if (w_req0) begin
                    w_owner_nxt = ST_BUSY0;
                    w_last_nxt  = 1'b0;
                end else if (w_req1) begin
                    w_owner_nxt = ST_BUSY1;
                    w_last_nxt  = 1'b1;
                end
            end
            // Release on completion, or when the owner withdraws its request
            // (abort); in the abort case ds.read/write already follow the
            // dropped strobes, so nothing reaches the slave.
            ST_BUSY0: begin
                if (!w_req0 || !ds.stall) begin
                    w_owner_nxt = ST_IDLE;
                end
            end
            ST_BUSY1: begin
                if (!w_req1 || !ds.stall) begin
                    w_owner_nxt = ST_IDLE;
                end
            end
            default: begin
                w_owner_nxt = ST_IDLE;
            end
        endcase
    end

    // While reset is held the outputs already behave as IDLE, so a
    // transaction caught by reset is withdrawn from ds immediately.
    assign w_owner_eff = clk.rst ? ST_IDLE : r_owner;

    // ---------------------------------------------------------------
    // Output steering: purely combinational from owner and the owner's
    // request. Non-owners get stall=req and zero read data.
    // ---------------------------------------------------------------
    always_comb begin
        w_ds_read      = 1'b0;
        w_ds_write     = 1'b0;
        w_ds_address   = '0;
        w_ds_data_wr   = '0;
        w_ds_mask      = '0;
        w_m0_stall     = w_req0;
        w_m1_stall     = w_req1;
        w_m0_data_rd   = '0;
        w_m0_data_rd_2 = '0;
        w_m1_data_rd   = '0;
        w_m1_data_rd_2 = '0;
        case (w_owner_eff)
            ST_BUSY0: begin
                w_ds_read      = m0.read;
                w_ds_write     = m0.write;
                w_ds_address   = m0.address;
                w_ds_data_wr   = m0.data_wr;
                w_ds_mask      = m0.mask;
                w_m0_stall     = ds.stall;
                w_m0_data_rd   = ds.data_rd;
                w_m0_data_rd_2 = ds.data_rd_2;
            end
            ST_BUSY1: begin
                w_ds_read      = m1.read;
                w_ds_write     = m1.write;
                w_ds_address   = m1.address;
                w_ds_data_wr   = m1.data_wr;
                w_ds_mask      = m1.mask;
                w_m1_stall     = ds.stall;
                w_m1_data_rd   = ds.data_rd;
                w_m1_data_rd_2 = ds.data_rd_2;
            end
            default: begin
            end
        endcase
    end

    assign ds.read      = w_ds_read;
    assign ds.write     = w_ds_write;
    assign ds.address   = w_ds_address;
    assign ds.data_wr   = w_ds_data_wr;
    assign ds.mask      = w_ds_mask;

    assign m0.stall     = w_m0_stall;
    assign m0.data_rd   = w_m0_data_rd;
    assign m0.data_rd_2 = w_m0_data_rd_2;
    assign m1.stall     = w_m1_stall;
    assign m1.data_rd   = w_m1_data_rd;
    assign m1.data_rd_2 = w_m1_data_rd_2;

    // Interrupts are a broadcast, independent of who owns the bus.
    assign m0.interrupt = ds.interrupt;
    assign m1.interrupt = ds.interrupt;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed plus randomized checks of a round-robin and a fixed-priority arbiter.
// Both instances share master and slave stimulus; a cycle model predicts every output.
// Inputs are driven 1 time unit after the rising edge and sampled on the falling edge.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic   clk_base = 1'b0;
    logic   rst      = 1'b1;
    Clock_t clk;
    assign clk = '{base: clk_base, rst: rst};
    always #5 clk_base = ~clk_base;

    Bus_if m0_if ();
    Bus_if m1_if ();
    Bus_if ds_if ();
    Bus_if f0_if ();
    Bus_if f1_if ();
    Bus_if fds_if ();

    bus_arbiter #(.ROUND_ROBIN(1)) u_rr (.clk(clk), .m0(m0_if), .m1(m1_if), .ds(ds_if));
    bus_arbiter #(.ROUND_ROBIN(0)) u_fp (.clk(clk), .m0(f0_if), .m1(f1_if), .ds(fds_if));

    assign f0_if.read       = m0_if.read;
    assign f0_if.write      = m0_if.write;
    assign f0_if.address    = m0_if.address;
    assign f0_if.data_wr    = m0_if.data_wr;
    assign f0_if.mask       = m0_if.mask;
    assign f1_if.read       = m1_if.read;
    assign f1_if.write      = m1_if.write;
    assign f1_if.address    = m1_if.address;
    assign f1_if.data_wr    = m1_if.data_wr;
    assign f1_if.mask       = m1_if.mask;
    assign fds_if.stall     = ds_if.stall;
    assign fds_if.data_rd   = ds_if.data_rd;
    assign fds_if.data_rd_2 = ds_if.data_rd_2;
    assign fds_if.interrupt = ds_if.interrupt;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  mask;
    } ds_out_t;

    typedef struct packed {
        logic        stall;
        logic [31:0] rdat;
        logic [31:0] rdat2;
        logic [5:0]  irq;
    } m_out_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: who holds the bus (-1 = nobody) and who was granted last,
    // one entry per instance (0 = round-robin, 1 = fixed priority).
    int holder[2] = '{-1, -1};
    int last[2]   = '{1, 1};
    bit done[2]   = '{1'b0, 1'b0};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit req_of(input int i);
        return (i == 0) ? (m0_if.read | m0_if.write) : (m1_if.read | m1_if.write);
    endfunction

    function automatic ds_out_t exp_ds(input int d);
        int h = rst ? -1 : holder[d];
        ds_out_t e = '0;
        if (h == 0) e = '{m0_if.read, m0_if.write, m0_if.address, m0_if.data_wr, m0_if.mask};
        if (h == 1) e = '{m1_if.read, m1_if.write, m1_if.address, m1_if.data_wr, m1_if.mask};
        return e;
    endfunction

    function automatic m_out_t exp_m(input int d, input int i);
        int h = rst ? -1 : holder[d];
        m_out_t e = '0;
        e.irq = ds_if.interrupt;
        if (h == i) begin
            e.stall = ds_if.stall;
            e.rdat  = ds_if.data_rd;
            e.rdat2 = ds_if.data_rd_2;
        end else begin
            e.stall = req_of(i);
        end
        return e;
    endfunction

    function automatic ds_out_t obs_ds(input int d);
        if (d == 0) return '{ds_if.read, ds_if.write, ds_if.address, ds_if.data_wr, ds_if.mask};
        return '{fds_if.read, fds_if.write, fds_if.address, fds_if.data_wr, fds_if.mask};
    endfunction

    function automatic m_out_t obs_m(input int d, input int i);
        if (d == 0 && i == 0) return '{m0_if.stall, m0_if.data_rd, m0_if.data_rd_2, m0_if.interrupt};
        if (d == 0)           return '{m1_if.stall, m1_if.data_rd, m1_if.data_rd_2, m1_if.interrupt};
        if (i == 0)           return '{f0_if.stall, f0_if.data_rd, f0_if.data_rd_2, f0_if.interrupt};
        return '{f1_if.stall, f1_if.data_rd, f1_if.data_rd_2, f1_if.interrupt};
    endfunction

    // Arbitration rules applied to the model at a rising edge.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                holder[d] = -1;
                last[d]   = 1;
            end else if (holder[d] < 0) begin
                int g = -1;
                if (req_of(0) && req_of(1)) g = (d == 0) ? 1 - last[d] : 1;
                else if (req_of(0))         g = 0;
                else if (req_of(1))         g = 1;
                holder[d] = g;
                if (g >= 0) last[d] = g;
            end else if (!req_of(holder[d]) || !ds_if.stall) begin
                holder[d] = -1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk_base);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_ds[%0d]", d), obs_ds(d), exp_ds(d));
            check($sformatf("model_m0[%0d]", d), obs_m(d, 0), exp_m(d, 0));
            check($sformatf("model_m1[%0d]", d), obs_m(d, 1), exp_m(d, 1));
        end
        done[0] = req_of(0) && !m0_if.stall;
        done[1] = req_of(1) && !m1_if.stall;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk_base);
        #1;
    endtask

    task automatic set_master(input int i, input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] mk);
        if (i == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.data_wr = wd; m0_if.mask = mk;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.data_wr = wd; m1_if.mask = mk;
        end
    endtask

    initial begin
        bit prev_rst;
        set_master(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ds_if.stall = 1'b0; ds_if.data_rd = '0; ds_if.data_rd_2 = '0;
        ds_if.interrupt = 6'b000001;

        // Reset held, m0 requesting: stall follows req, ds idle.
        settle();
        check("rst_ds_read", ds_if.read, 1'b0);
        check("rst_m0_stall", m0_if.stall, 1'b1);
        check("rst_m0_rdat", m0_if.data_rd, 32'h0);
        advance();
        rst = 1'b0;
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("post_rst_m0_stall", m0_if.stall, 1'b0);
        advance();

        // Single m0 read, zero-wait slave.
        set_master(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        ds_if.data_rd = 32'hDEAD_BEEF;
        settle();
        check("t1_stall_t", m0_if.stall, 1'b1);
        check("t1_dsread_t", ds_if.read, 1'b0);
        advance();
        settle();
        check("t1_dsread_t1", ds_if.read, 1'b1);
        check("t1_addr_t1", ds_if.address, 32'h0000_1000);
        check("t1_stall_t1", m0_if.stall, 1'b0);
        check("t1_rdat_t1", m0_if.data_rd, 32'hDEAD_BEEF);
        advance();
        settle();
        check("t1_idle_stall_t2", m0_if.stall, 1'b1);
        check("t1_idle_dsread_t2", ds_if.read, 1'b0);
        advance();
        settle();
        advance();
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();

        // Simultaneous requests right after reset, round-robin.
        rst = 1'b1;
        settle();
        advance();
        rst = 1'b0;
        set_master(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        set_master(1, 1'b0, 1'b1, 32'h200, 32'h5A5A_5A5A, 4'b0011);
        settle();
        check("t2_m0_stall_t", m0_if.stall, 1'b1);
        check("t2_m1_stall_t", m1_if.stall, 1'b1);
        check("t2_ds_idle_t", {ds_if.read, ds_if.write}, 2'b00);
        advance();
        settle();
        check("t2_m0_first", {ds_if.read, ds_if.address}, {1'b1, 32'h100});
        check("t2_m1_stall_t1", m1_if.stall, 1'b1);
        advance();
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("t2_m1_stall_t2", m1_if.stall, 1'b1);
        check("t2_ds_write_t2", ds_if.write, 1'b0);
        advance();
        settle();
        check("t2_m1_ds", {ds_if.write, ds_if.address, ds_if.data_wr, ds_if.mask},
              {1'b1, 32'h200, 32'h5A5A_5A5A, 4'b0011});
        check("t2_m1_stall_t3", m1_if.stall, 1'b0);
        advance();
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();

        // Both continuously requesting: RR alternates, FP always picks m1.
        set_master(0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'h0);
        set_master(1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            settle();
            check($sformatf("t3_arb_gap[%0d]", k), {ds_if.read, fds_if.read}, 2'b00);
            advance();
            settle();
            check($sformatf("t3_rr_grant[%0d]", k), ds_if.address,
                  (k % 2 == 1) ? 32'h0000_0B00 : 32'h0000_0A00);
            check($sformatf("t3_fp_grant[%0d]", k), fds_if.address, 32'h0000_0B00);
            check($sformatf("t3_fp_m0_stall[%0d]", k), f0_if.stall, 1'b1);
            advance();
        end

        // Fixed priority: m0 gets the bus once m1 stops requesting.
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        check("t4_fp_m0_wait", f0_if.stall, 1'b1);
        advance();
        settle();
        check("t4_fp_m0_grant", {fds_if.read, fds_if.address, f0_if.stall}, {1'b1, 32'h0000_0A00, 1'b0});
        advance();
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();

        // m1 read with three downstream wait states; m0 queues behind it.
        set_master(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        ds_if.stall = 1'b1;
        ds_if.data_rd = 32'h1234_5678;
        settle();
        advance();
        set_master(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        for (int j = 0; j < 3; j++) begin
            settle();
            check($sformatf("t5_m1_stall[%0d]", j), m1_if.stall, ds_if.stall);
            check($sformatf("t5_addr[%0d]", j), {ds_if.read, ds_if.address}, {1'b1, 32'h300});
            check($sformatf("t5_m0_stall[%0d]", j), m0_if.stall, 1'b1);
            advance();
        end
        ds_if.stall = 1'b0;
        settle();
        check("t5_complete", {m1_if.stall, m1_if.data_rd, ds_if.address}, {1'b0, 32'h1234_5678, 32'h300});
        check("t5_m0_still_stalled", m0_if.stall, 1'b1);
        advance();
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();
        settle();
        check("t5_m0_served", {ds_if.read, ds_if.address}, {1'b1, 32'h400});
        advance();
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();

        // Reset while m1 owns the bus and the slave is stalling.
        set_master(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
        ds_if.stall = 1'b1;
        settle();
        advance();
        settle();
        check("t6_busy1", {ds_if.read, ds_if.address}, {1'b1, 32'h500});
        advance();
        rst = 1'b1;
        settle();
        check("t6_rst_ds", {ds_if.read, ds_if.write}, 2'b00);
        check("t6_rst_m1_stall", m1_if.stall, 1'b1);
        check("t6_irq", {m0_if.interrupt, m1_if.interrupt}, {6'b000001, 6'b000001});
        advance();
        rst = 1'b0;
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        ds_if.stall = 1'b0;
        settle();
        check("t6_idle_ds", {ds_if.read, ds_if.write}, 2'b00);
        advance();
        set_master(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
        set_master(1, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        settle();
        advance();
        settle();
        check("t6_tie_m0_first", {ds_if.read, ds_if.address}, {1'b1, 32'h600});
        check("t6_irq_busy", {m0_if.interrupt, m1_if.interrupt}, {6'b000001, 6'b000001});
        advance();
        set_master(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();
        settle();
        check("t6_then_m1", {ds_if.read, ds_if.address}, {1'b1, 32'h700});
        advance();
        set_master(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        settle();
        advance();

        // Randomized traffic: masters hold until completion, sometimes abort;
        // slave stalls randomly; occasional resets.
        prev_rst = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 299) == 0);
            ds_if.stall     = ($urandom_range(0, 2) == 0);
            ds_if.data_rd   = $urandom;
            ds_if.data_rd_2 = $urandom;
            if ($urandom_range(0, 15) == 0) ds_if.interrupt = 6'($urandom);
            for (int i = 0; i < 2; i++) begin
                if (prev_rst || done[i] || (req_of(i) && $urandom_range(0, 19) == 0))
                    set_master(i, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                if (!req_of(i) && $urandom_range(0, 2) == 0) begin
                    bit wr = 1'($urandom);
                    set_master(i, !wr, wr, $urandom, $urandom, 4'($urandom));
                end
            end
            settle();
            prev_rst = rst;
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
